// File: rtl/dac_spi_rx_if.sv
// Bundle for the DAC SPI receive link: raw serial pins in, decoded frame fields out.
// The master side drives the serial pins; the slave side is the receiver.
interface dac_spi_rx_if;
  logic        spi_sclk;
  logic        spi_sync;
  logic        spi_data;
  logic [3:0]  rx_comm;
  logic [3:0]  rx_addr;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        rx_err;
  logic        busy;
  logic [15:0] frame_cnt;

  modport master (
    output spi_sclk, spi_sync, spi_data,
    input  rx_comm, rx_addr, rx_data, rx_valid, rx_err, busy, frame_cnt
  );

  modport slave (
    input  spi_sclk, spi_sync, spi_data,
    output rx_comm, rx_addr, rx_data, rx_valid, rx_err, busy, frame_cnt
  );
endinterface

// File: rtl/dac_spi_rx.sv
// SPI frame receiver for the DAC write link: oversamples sync/sclk/data on clk,
// shifts one {pad,comm,addr,data} frame per sync-low window, pulses valid or err.
module dac_spi_rx #(
  parameter int DWIDTH  = 24,
  parameter int TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst,
  dac_spi_rx_if.slave   bus
);

  localparam int FLEN = DWIDTH + 1;
  localparam int TW   = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_CHECK,
    ST_WAIT
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic r_sync_s1, r_sync_s2, r_sync_s3;
  logic r_data_s1, r_data_s2;

  logic [FLEN-1:0] r_shreg;
  logic [5:0]      r_bit_cnt;
  logic [TW-1:0]   r_tmo_cnt;
  logic [3:0]      r_comm;
  logic [3:0]      r_addr;
  logic [15:0]     r_data;
  logic            r_valid;
  logic            r_err;
  logic [15:0]     r_frame_cnt;

  logic w_sclk_rise;
  logic w_sync_fall;
  logic w_sync_rise;
  logic w_good;
  logic w_clear;
  logic w_shift;
  logic w_tmo_inc;
  logic w_accept;
  logic w_reject;

  // sync idles high so reset cannot fake a falling edge on an idle link
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_sync_s1 <= 1'b1;
      r_sync_s2 <= 1'b1;
      r_sync_s3 <= 1'b1;
      r_data_s1 <= 1'b0;
      r_data_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= bus.spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_sync_s1 <= bus.spi_sync;
      r_sync_s2 <= r_sync_s1;
      r_sync_s3 <= r_sync_s2;
      r_data_s1 <= bus.spi_data;
      r_data_s2 <= r_data_s1;
    end
  end

  assign w_sclk_rise = r_sclk_s2 & ~r_sclk_s3;
  assign w_sync_fall = ~r_sync_s2 & r_sync_s3;
  assign w_sync_rise = r_sync_s2 & ~r_sync_s3;
  assign w_good      = (r_bit_cnt == 6'(FLEN)) && !r_shreg[FLEN-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_shift      = 1'b0;
    w_tmo_inc    = 1'b0;
    w_accept     = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_sync_fall) begin
          w_state_next = ST_SHIFT;
          w_clear      = 1'b1;
        end
      end
      ST_SHIFT: begin
        // an sclk edge landing with the sync rise still counts as a bit
        if (w_sclk_rise) begin
          w_shift = 1'b1;
        end else begin
          w_tmo_inc = 1'b1;
        end
        if (w_sync_rise) begin
          w_state_next = ST_CHECK;
        end else if (!w_sclk_rise && (r_tmo_cnt == TW'(TIMEOUT - 1))) begin
          w_state_next = ST_WAIT;
          w_reject     = 1'b1;
        end
      end
      ST_CHECK: begin
        if (w_good) begin
          w_accept = 1'b1;
        end else begin
          w_reject = 1'b1;
        end
        if (w_sync_fall) begin
          w_state_next = ST_SHIFT;
          w_clear      = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (w_sync_rise) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_tmo_cnt   <= '0;
      r_comm      <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_valid <= w_accept;
      r_err   <= w_reject;
      if (w_clear) begin
        r_shreg   <= '0;
        r_bit_cnt <= '0;
        r_tmo_cnt <= '0;
      end else if (w_shift) begin
        r_shreg   <= {r_shreg[FLEN-2:0], r_data_s2};
        r_tmo_cnt <= '0;
        if (r_bit_cnt != 6'd63) begin
          r_bit_cnt <= r_bit_cnt + 6'd1;
        end
      end else if (w_tmo_inc) begin
        r_tmo_cnt <= r_tmo_cnt + TW'(1);
      end
      if (w_accept) begin
        r_comm      <= r_shreg[DWIDTH-1 -: 4];
        r_addr      <= r_shreg[DWIDTH-5 -: 4];
        r_data      <= r_shreg[15:0];
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign bus.rx_comm   = r_comm;
  assign bus.rx_addr   = r_addr;
  assign bus.rx_data   = r_data;
  assign bus.rx_valid  = r_valid;
  assign bus.rx_err    = r_err;
  assign bus.busy      = (r_state == ST_SHIFT);
  assign bus.frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_dac_spi_rx.sv
// Directed bench for dac_spi_rx: a table of whole frames plus hand-written
// sequences for timeout, mid-frame reset and back-to-back frames with counter wrap.
module tb_dac_spi_rx;

  logic clk = 1'b0;
  logic rst = 1'b1;

  dac_spi_rx_if bus ();

  dac_spi_rx #(.DWIDTH(24), .TIMEOUT(4096)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          nbits;
    logic [31:0] bits;
    logic        good;
    logic [3:0]  comm;
    logic [3:0]  addr;
    logic [15:0] data;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs [8];

  int n_checks = 0;
  int n_errors = 0;
  int tot_valid = 0;
  int tot_err = 0;
  int both_cnt = 0;
  logic [15:0] cnt_log [$];

  always @(negedge clk) begin
    if (bus.rx_valid && bus.rx_err) both_cnt++;
    if (bus.rx_valid) begin
      tot_valid++;
      cnt_log.push_back(bus.frame_cnt);
    end
    if (bus.rx_err) tot_err++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame on the wire: data set 16 clk before each sclk rise and held 16 clk after it.
  task automatic send_bits(input int nbits, input logic [31:0] bits);
    bus.spi_sync = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      bus.spi_data = bits[i];
      repeat (16) @(negedge clk);
      bus.spi_sclk = 1'b1;
      repeat (16) @(negedge clk);
      bus.spi_sclk = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int vpos, epos, vcnt, ecnt, v0, e0, waited;
    logic seen;

    vecs[0] = '{25, 32'h0030A5C3, 1'b1, 4'h3, 4'h0, 16'hA5C3, 16'd1};
    vecs[1] = '{24, 32'h00ABCDEF, 1'b0, 4'h3, 4'h0, 16'hA5C3, 16'd1};
    vecs[2] = '{26, 32'h0030A5C3, 1'b0, 4'h3, 4'h0, 16'hA5C3, 16'd1};
    vecs[3] = '{25, 32'h0130A5C3, 1'b0, 4'h3, 4'h0, 16'hA5C3, 16'd1};
    vecs[4] = '{25, 32'h00C71234, 1'b1, 4'hC, 4'h7, 16'h1234, 16'd2};
    vecs[5] = '{0,  32'h00000000, 1'b0, 4'hC, 4'h7, 16'h1234, 16'd2};
    vecs[6] = '{25, 32'h00000000, 1'b1, 4'h0, 4'h0, 16'h0000, 16'd3};
    vecs[7] = '{25, 32'h00FFFFFF, 1'b1, 4'hF, 4'hF, 16'hFFFF, 16'd4};

    bus.spi_sclk = 1'b0;
    bus.spi_sync = 1'b1;
    bus.spi_data = 1'b0;

    // Power-on reset
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
    chk("reset_err",   {31'd0, bus.rx_err},   32'd0);
    chk("reset_busy",  {31'd0, bus.busy},     32'd0);
    chk("reset_data",  {16'd0, bus.rx_data},  32'd0);
    chk("reset_cnt",   {16'd0, bus.frame_cnt}, 32'd0);
    $display("reset: valid=%0d err=%0d busy=%0d cnt=%0h",
             bus.rx_valid, bus.rx_err, bus.busy, bus.frame_cnt);

    // Table-driven frames; pulse must land on the 4th negedge after raw sync rise
    for (int v = 0; v < 8; v++) begin
      send_bits(vecs[v].nbits, vecs[v].bits);
      chk($sformatf("v%0d_busy_in", v), {31'd0, bus.busy}, 32'd1);
      bus.spi_sync = 1'b1;
      vpos = 0; epos = 0; vcnt = 0; ecnt = 0;
      for (int i = 1; i <= 8; i++) begin
        @(negedge clk);
        if (bus.rx_valid) begin vpos = i; vcnt++; end
        if (bus.rx_err)   begin epos = i; ecnt++; end
      end
      chk($sformatf("v%0d_valid_cnt", v), vcnt, vecs[v].good ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_err_cnt", v),   ecnt, vecs[v].good ? 32'd0 : 32'd1);
      chk($sformatf("v%0d_pulse_pos", v), vecs[v].good ? vpos : epos, 32'd4);
      chk($sformatf("v%0d_comm", v), {28'd0, bus.rx_comm}, {28'd0, vecs[v].comm});
      chk($sformatf("v%0d_addr", v), {28'd0, bus.rx_addr}, {28'd0, vecs[v].addr});
      chk($sformatf("v%0d_data", v), {16'd0, bus.rx_data}, {16'd0, vecs[v].data});
      chk($sformatf("v%0d_cnt", v),  {16'd0, bus.frame_cnt}, {16'd0, vecs[v].cnt});
      chk($sformatf("v%0d_busy_out", v), {31'd0, bus.busy}, 32'd0);
      $display("frame %0d: bits=%0d valid_at=%0d err_at=%0d comm=%0h addr=%0h data=%0h cnt=%0h",
               v, vecs[v].nbits, vpos, epos, bus.rx_comm, bus.rx_addr, bus.rx_data, bus.frame_cnt);
      repeat (8) @(negedge clk);
    end

    // Timeout: 10 bits then sclk stops with sync held low
    e0 = tot_err; v0 = tot_valid;
    send_bits(10, 32'h000002AB);
    seen = 1'b0; waited = 0;
    while (!seen && waited < 5000) begin
      @(negedge clk);
      waited++;
      if (bus.rx_err) seen = 1'b1;
    end
    chk("tmo_err_seen", {31'd0, seen}, 32'd1);
    chk("tmo_window", {31'd0, (waited >= 4060 && waited <= 4090)}, 32'd1);
    repeat (20) @(negedge clk);
    chk("tmo_busy", {31'd0, bus.busy}, 32'd0);
    bus.spi_sync = 1'b1;
    repeat (12) @(negedge clk);
    chk("tmo_err_once", tot_err - e0, 32'd1);
    chk("tmo_no_valid", tot_valid - v0, 32'd0);
    chk("tmo_cnt_kept", {16'd0, bus.frame_cnt}, 32'd4);
    $display("timeout: err after %0d clk, busy=%0d", waited, bus.busy);

    // Reset in the middle of a frame; link ends the frame while reset is held
    send_bits(8, 32'h000000A5);
    e0 = tot_err; v0 = tot_valid;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    bus.spi_sync = 1'b1;
    bus.spi_sclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("mid_rst_no_err",   tot_err - e0,   32'd0);
    chk("mid_rst_no_valid", tot_valid - v0, 32'd0);
    chk("mid_rst_comm", {28'd0, bus.rx_comm}, 32'd0);
    chk("mid_rst_data", {16'd0, bus.rx_data}, 32'd0);
    chk("mid_rst_cnt",  {16'd0, bus.frame_cnt}, 32'd0);
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    $display("mid-frame reset: data=%0h cnt=%0h busy=%0d", bus.rx_data, bus.frame_cnt, bus.busy);

    // Back-to-back frames with 3 clk of sync high, counter preloaded to wrap
    force dut.r_frame_cnt = 16'hFFFF;
    @(negedge clk);
    release dut.r_frame_cnt;
    @(negedge clk);
    chk("b2b_preload", {16'd0, bus.frame_cnt}, 32'h0000FFFF);
    cnt_log.delete();
    e0 = tot_err;
    send_bits(25, 32'h00512345);
    bus.spi_sync = 1'b1;
    repeat (3) @(negedge clk);
    send_bits(25, 32'h006A6789);
    bus.spi_sync = 1'b1;
    repeat (12) @(negedge clk);
    chk("b2b_valid_cnt", cnt_log.size(), 32'd2);
    if (cnt_log.size() >= 2) begin
      chk("b2b_wrap_cnt",  {16'd0, cnt_log[0]}, 32'h00000000);
      chk("b2b_second_cnt", {16'd0, cnt_log[1]}, 32'h00000001);
    end
    chk("b2b_no_err", tot_err - e0, 32'd0);
    chk("b2b_comm", {28'd0, bus.rx_comm}, 32'h6);
    chk("b2b_addr", {28'd0, bus.rx_addr}, 32'hA);
    chk("b2b_data", {16'd0, bus.rx_data}, 32'h6789);
    $display("back-to-back: pulses=%0d comm=%0h addr=%0h data=%0h cnt=%0h",
             cnt_log.size(), bus.rx_comm, bus.rx_addr, bus.rx_data, bus.frame_cnt);

    chk("never_both", both_cnt, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
